tlb_credits_rd: RTL and testbench
=================================

TLB_CREDITS_RD -- requirements
Module: tlb_credits_rd

Interface
REQ-001 SHALL have parameter ID_REG, default 0: number of the associated vFPGA.
REQ-002 SHALL have parameter DATA_BITS, default AXI_DATA_BITS: data bus width; BEAT_LOG_BITS = log2(DATA_BITS/8).
REQ-003 SHALL have parameter N_CREDITS, default 64: receive-buffer depth in beats; CRED_BITS = clog2(N_CREDITS+1).
REQ-004 SHALL have parameter N_OUTSTANDING, default 8: maximum number of in-flight read requests (power of two).
REQ-005 SHALL have port aclk, input, 1 bit: the single clock.
REQ-006 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port s_req, dmaIntf.s: upstream read requests.
REQ-008 SHALL have port m_req, dmaIntf.m: downstream read requests.
REQ-009 SHALL have port rxfer, input, 1 bit: one read-data beat drained from the receive buffer.
REQ-010 SHALL have port credits, output, CRED_BITS: current free-beat count.
REQ-011 SHALL have port outstanding, output, clog2(N_OUTSTANDING+1) bits: in-flight request count.
REQ-012 SHALL have port cmpl, output, 1 bit: one-cycle pulse when all beats of the oldest request have drained.
REQ-013 SHALL have port err_oversize, output, 1 bit: sticky flag, request larger than N_CREDITS.
REQ-014 SHALL have port err_underflow, output, 1 bit: sticky flag, rxfer with nothing in flight.

Function
REQ-015 SHALL compute n_beats = ceil(s_req.req.len / (DATA_BITS/8)), sized LEN_BITS-BEAT_LOG_BITS+1 bits.
REQ-016 SHALL pass m_req.req = s_req.req combinationally.
REQ-017 SHALL drive s_req.ready = m_req.valid = s_req.valid & m_req.ready & (credits_reg >= n_beats) & !fifo_full; the check uses the registered count only.
REQ-018 SHALL never assert m_req.valid while any gating term is false; s_req.req is held by upstream until accepted.
REQ-019 SHALL update credits each cycle as credits - (issue ? n_beats : 0) + (rxfer_valid ? 1 : 0), where rxfer_valid = rxfer & (outstanding != 0).
REQ-020 SHALL, on issue with n_beats > 0, push n_beats into a length FIFO of depth N_OUTSTANDING; len = 0 SHALL be forwarded with no credit charge and no FIFO push.
REQ-021 SHALL keep beat counter rx_cnt; on rxfer_valid, if rx_cnt+1 == fifo head then pop, clear rx_cnt to 0, and assert cmpl on the next cycle; otherwise increment rx_cnt.
REQ-022 SHALL allow push and pop in the same cycle; outstanding stays unchanged in that case.
REQ-023 SHALL evaluate a pop against the head before the same-cycle push, so a request pushed into an empty FIFO cannot be popped in that cycle.
REQ-024 SHALL ignore rxfer when outstanding == 0 (credits unchanged) and set err_underflow.
REQ-025 SHALL set err_oversize when s_req.valid and n_beats > N_CREDITS; the request stays blocked (ready = 0).
REQ-026 SHALL register s_req.rsp from m_req.rsp with 1 cycle latency.
REQ-027 SHALL guarantee credits never exceeds N_CREDITS and never goes negative.
REQ-028 SHALL drive credits and outstanding directly from registers.

Reset
REQ-029 SHALL, while areset = 1 at a clock edge, set credits = N_CREDITS, empty the FIFO, and clear rx_cnt, outstanding, cmpl, err_oversize, err_underflow and s_req.rsp to 0.
REQ-030 SHALL drop in-flight bookkeeping on a mid-operation reset; combinational outputs SHALL still follow REQ-017 using the reset register values.

Verification
REQ-031 SHALL cover this case: DATA_BITS=512, N_CREDITS=64; issue len=4096 -> accepted same cycle, credits 64->0; next len=64 -> blocked; one rxfer -> credits=1, len=64 accepted next cycle.
REQ-032 SHALL cover this case: len=100 -> n_beats=2, credits drop by 2; two rxfer -> cmpl pulses exactly once, the cycle after the 2nd rxfer.
REQ-033 SHALL cover this case: N_OUTSTANDING=8; issue 8 requests of len=64 with no rxfer -> 9th blocked despite credits=56; one rxfer -> cmpl pulse, 9th accepted.
REQ-034 SHALL cover this case: issue and rxfer in the same cycle with credits=10, n_beats=4 and outstanding>0 -> credits=7 next cycle.
REQ-035 SHALL cover this case: len=8192 (128 beats) with N_CREDITS=64 -> err_oversize=1 and ready stays 0; rxfer at idle -> err_underflow=1 and credits unchanged.
REQ-036 SHALL cover this case: areset mid-transfer with credits=20 and outstanding=3 -> next cycle credits=64, outstanding=0, flags=0, cmpl=0.

Source files
------------

// File: rtl/tlb_credits_rd.sv
// Credit-based read-request gate: admits a read only when the receive buffer has room
// for all of its beats, and tracks in-flight requests so completions can be signalled.
module tlb_credits_rd #(
  parameter int unsigned ID_REG        = 0,
  parameter int unsigned DATA_BITS     = 512,
  parameter int unsigned N_CREDITS     = 64,
  parameter int unsigned N_OUTSTANDING = 8,
  parameter int unsigned LEN_BITS      = 28,
  parameter int unsigned VADDR_BITS    = 48,
  parameter int unsigned CTL_BITS      = 8,
  parameter int unsigned RSP_BITS      = 4
) (
  input  logic                                   aclk,
  input  logic                                   areset,

  input  logic                                   s_req_valid,
  output logic                                   s_req_ready,
  input  logic [VADDR_BITS-1:0]                  s_req_vaddr,
  input  logic [LEN_BITS-1:0]                    s_req_len,
  input  logic [CTL_BITS-1:0]                    s_req_ctl,
  output logic [RSP_BITS-1:0]                    s_req_rsp,

  output logic                                   m_req_valid,
  input  logic                                   m_req_ready,
  output logic [VADDR_BITS-1:0]                  m_req_vaddr,
  output logic [LEN_BITS-1:0]                    m_req_len,
  output logic [CTL_BITS-1:0]                    m_req_ctl,
  input  logic [RSP_BITS-1:0]                    m_req_rsp,

  input  logic                                   rxfer,
  output logic [$clog2(N_CREDITS+1)-1:0]         credits,
  output logic [$clog2(N_OUTSTANDING+1)-1:0]     outstanding,
  output logic                                   cmpl,
  output logic                                   err_oversize,
  output logic                                   err_underflow
);

  localparam int unsigned BEAT_LOG_BITS = $clog2(DATA_BITS/8);
  localparam int unsigned CRED_BITS     = $clog2(N_CREDITS+1);
  localparam int unsigned OUT_BITS      = $clog2(N_OUTSTANDING+1);
  localparam int unsigned PTR_BITS      = $clog2(N_OUTSTANDING);
  localparam int unsigned NB_BITS       = LEN_BITS - BEAT_LOG_BITS + 1;

  // Elaboration-time sanity on the configuration of this vFPGA instance
  if ((N_OUTSTANDING < 2) || ((N_OUTSTANDING & (N_OUTSTANDING - 1)) != 0) ||
      (DATA_BITS < 16) || (N_CREDITS < 1) || (ID_REG > 255)) begin : g_param_chk
    $error("tlb_credits_rd: unsupported parameter set");
  end

  logic [CRED_BITS-1:0] credits_q, credits_d;
  logic [CRED_BITS-1:0] rx_cnt_q, rx_cnt_d;
  logic [OUT_BITS-1:0]  outstanding_q, outstanding_d;
  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic                 cmpl_q, cmpl_d;
  logic                 err_oversize_q, err_oversize_d;
  logic                 err_underflow_q, err_underflow_d;
  logic [RSP_BITS-1:0]  rsp_q;
  logic [CRED_BITS-1:0] len_fifo_q [N_OUTSTANDING];

  logic [NB_BITS-1:0]   n_beats;
  logic                 fifo_full;
  logic                 credit_ok;
  logic                 issue;
  logic                 push;
  logic                 pop;
  logic                 rxfer_valid;
  logic [CRED_BITS-1:0] head;

  // Request admission and beat accounting
  always_comb begin
    n_beats     = NB_BITS'(s_req_len >> BEAT_LOG_BITS) +
                  NB_BITS'(|s_req_len[BEAT_LOG_BITS-1:0]);
    fifo_full   = (outstanding_q == OUT_BITS'(N_OUTSTANDING));
    credit_ok   = (32'(credits_q) >= 32'(n_beats));
    issue       = s_req_valid & m_req_ready & credit_ok & ~fifo_full;
    push        = issue & (n_beats != '0);
    rxfer_valid = rxfer & (outstanding_q != '0);
    head        = len_fifo_q[rd_ptr_q];
    // Pop is judged on the current head, so a same-cycle push never completes here
    pop         = rxfer_valid & ((rx_cnt_q + CRED_BITS'(1)) == head);
  end

  // Next-state logic
  always_comb begin
    credits_d       = credits_q;
    rx_cnt_d        = rx_cnt_q;
    outstanding_d   = outstanding_q + OUT_BITS'(push) - OUT_BITS'(pop);
    wr_ptr_d        = wr_ptr_q + PTR_BITS'(push);
    rd_ptr_d        = rd_ptr_q + PTR_BITS'(pop);
    cmpl_d          = pop;
    err_oversize_d  = err_oversize_q | (s_req_valid & (32'(n_beats) > N_CREDITS));
    err_underflow_d = err_underflow_q | (rxfer & (outstanding_q == '0));

    if (issue) begin
      credits_d = credits_d - CRED_BITS'(n_beats);
    end
    if (rxfer_valid) begin
      credits_d = credits_d + CRED_BITS'(1);
      rx_cnt_d  = pop ? '0 : rx_cnt_q + CRED_BITS'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      credits_q       <= CRED_BITS'(N_CREDITS);
      rx_cnt_q        <= '0;
      outstanding_q   <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cmpl_q          <= 1'b0;
      err_oversize_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      rsp_q           <= '0;
    end else begin
      credits_q       <= credits_d;
      rx_cnt_q        <= rx_cnt_d;
      outstanding_q   <= outstanding_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cmpl_q          <= cmpl_d;
      err_oversize_q  <= err_oversize_d;
      err_underflow_q <= err_underflow_d;
      rsp_q           <= m_req_rsp;
    end
  end

  // Length storage needs no reset: occupancy is defined by the pointers
  always_ff @(posedge aclk) begin
    if (push) begin
      len_fifo_q[wr_ptr_q] <= CRED_BITS'(n_beats);
    end
  end

  assign s_req_ready   = issue;
  assign m_req_valid   = issue;
  assign m_req_vaddr   = s_req_vaddr;
  assign m_req_len     = s_req_len;
  assign m_req_ctl     = s_req_ctl;
  assign s_req_rsp     = rsp_q;
  assign credits       = credits_q;
  assign outstanding   = outstanding_q;
  assign cmpl          = cmpl_q;
  assign err_oversize  = err_oversize_q;
  assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_tlb_credits_rd.sv
// Bench for tlb_credits_rd: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-of-remaining-beats reference model.
module tb_tlb_credits_rd;

  localparam int unsigned LEN_BITS   = 28;
  localparam int unsigned VADDR_BITS = 48;
  localparam int unsigned CTL_BITS   = 8;
  localparam int unsigned RSP_BITS   = 4;
  localparam int          NC         = 64;
  localparam int          NO         = 8;
  localparam int          BB         = 64;

  logic                  aclk;
  logic                  areset;
  logic                  s_req_valid;
  logic                  s_req_ready;
  logic [VADDR_BITS-1:0] s_req_vaddr;
  logic [LEN_BITS-1:0]   s_req_len;
  logic [CTL_BITS-1:0]   s_req_ctl;
  logic [RSP_BITS-1:0]   s_req_rsp;
  logic                  m_req_valid;
  logic                  m_req_ready;
  logic [VADDR_BITS-1:0] m_req_vaddr;
  logic [LEN_BITS-1:0]   m_req_len;
  logic [CTL_BITS-1:0]   m_req_ctl;
  logic [RSP_BITS-1:0]   m_req_rsp;
  logic                  rxfer;
  logic [6:0]            credits;
  logic [3:0]            outstanding;
  logic                  cmpl;
  logic                  err_oversize;
  logic                  err_underflow;

  tlb_credits_rd #(
    .ID_REG(0), .DATA_BITS(512), .N_CREDITS(NC), .N_OUTSTANDING(NO),
    .LEN_BITS(LEN_BITS), .VADDR_BITS(VADDR_BITS), .CTL_BITS(CTL_BITS), .RSP_BITS(RSP_BITS)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_vaddr(s_req_vaddr),
    .s_req_len(s_req_len), .s_req_ctl(s_req_ctl), .s_req_rsp(s_req_rsp),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_vaddr(m_req_vaddr),
    .m_req_len(m_req_len), .m_req_ctl(m_req_ctl), .m_req_rsp(m_req_rsp),
    .rxfer(rxfer), .credits(credits), .outstanding(outstanding), .cmpl(cmpl),
    .err_oversize(err_oversize), .err_underflow(err_underflow)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_credits = NC;
  int              m_q[$];
  bit              m_cmpl = 0, m_ovf = 0, m_udf = 0;
  logic [RSP_BITS-1:0] m_rsp = '0;
  bit              model_on = 0;

  // Inputs currently applied
  bit              cur_rst, cur_valid, cur_mrdy, cur_rx;
  int              cur_len;
  logic [RSP_BITS-1:0] cur_rsp;

  typedef struct {
    bit drain;
    bit rst;
    bit valid;
    int len;
    bit rx;
    bit e_rdy;
    int e_cred;
    int e_out;
    bit e_cmpl;
    bit e_ovf;
    bit e_udf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit drain, bit rst, bit valid, int len, bit rx, bit e_rdy,
                              int e_cred, int e_out, bit e_cmpl, bit e_ovf, bit e_udf);
    vec_t v;
    v.drain = drain; v.rst = rst; v.valid = valid; v.len = len; v.rx = rx;
    v.e_rdy = e_rdy; v.e_cred = e_cred; v.e_out = e_out; v.e_cmpl = e_cmpl;
    v.e_ovf = e_ovf; v.e_udf = e_udf;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit valid, input int len, input bit mrdy, input bit rx);
    @(negedge aclk);
    cur_rst = rst; cur_valid = valid; cur_len = len; cur_mrdy = mrdy; cur_rx = rx;
    cur_rsp = RSP_BITS'($urandom);
    areset      = rst;
    s_req_valid = valid;
    s_req_len   = LEN_BITS'(len);
    s_req_vaddr = VADDR_BITS'({$urandom, $urandom});
    s_req_ctl   = CTL_BITS'($urandom);
    m_req_ready = mrdy;
    rxfer       = rx;
    m_req_rsp   = cur_rsp;
    #1;
  endtask

  function automatic bit model_ready();
    int nb;
    nb = (cur_len + BB - 1) / BB;
    return cur_valid && cur_mrdy && (m_credits >= nb) && (m_q.size() < NO);
  endfunction

  // Compare against the model, then advance the model across the next rising edge
  task automatic check_and_tick(output bit accepted);
    int nb;
    bit rdy;
    bit rv;
    nb  = (cur_len + BB - 1) / BB;
    rdy = model_ready();
    if (model_on) begin
      chk("m_credits", credits, m_credits);
      chk("m_outstanding", outstanding, m_q.size());
      chk("m_cmpl", cmpl, m_cmpl);
      chk("m_err_oversize", err_oversize, m_ovf);
      chk("m_err_underflow", err_underflow, m_udf);
      chk("m_rsp", s_req_rsp, m_rsp);
      chk("m_ready", s_req_ready, rdy);
      chk("m_valid", m_req_valid, rdy);
      chk("m_len_pass", m_req_len, s_req_len);
      chk("m_vaddr_pass", m_req_vaddr, s_req_vaddr);
      chk("m_ctl_pass", m_req_ctl, s_req_ctl);
    end
    accepted = rdy;
    if (cur_rst) begin
      m_credits = NC; m_q.delete(); m_cmpl = 0; m_ovf = 0; m_udf = 0; m_rsp = '0;
    end else begin
      rv = cur_rx && (m_q.size() > 0);
      if (cur_rx && m_q.size() == 0) m_udf = 1;
      if (cur_valid && nb > NC) m_ovf = 1;
      m_cmpl = 0;
      if (rv) begin
        m_q[0] = m_q[0] - 1;
        if (m_q[0] == 0) begin
          void'(m_q.pop_front());
          m_cmpl = 1;
        end
      end
      if (rdy && nb > 0) m_q.push_back(nb);
      m_credits = m_credits - (rdy ? nb : 0) + (rv ? 1 : 0);
      m_rsp = cur_rsp;
    end
    @(posedge aclk);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 300 && m_q.size() > 0; k++) begin
      drive(0, 0, 0, 1, 1);
      check_and_tick(acc);
    end
    if (m_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d requests left expected 0", m_q.size());
    end
  endtask

  initial begin
    bit acc;
    bit hold_valid;
    int hold_len;
    int r;

    areset = 1'b1; s_req_valid = 0; s_req_len = '0; s_req_vaddr = '0; s_req_ctl = '0;
    m_req_ready = 0; rxfer = 0; m_req_rsp = '0;

    // drain, rst, valid, len, rx | ready, credits, outstanding, cmpl, ovf, udf
    tbl.push_back(mk(0, 0, 1, 4096, 0, 1, 64, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   64, 0, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   64, 1, 0,  0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,   64, 0, 1,  1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  100, 0, 1, 64, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0, 62, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0, 63, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 64, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 64, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3456, 0, 1, 64, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1,  256, 1, 1, 10, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0,  7, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0,    0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8192, 0, 0, 64, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8192, 0, 0, 64, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,    0, 1, 0, 64, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 64, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 0,    0, 0, 0, 64, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0,    0, 0, 0, 64, 0, 0, 0, 0));

    drive(1, 0, 0, 1, 0);
    check_and_tick(acc);
    model_on = 1;
    drive(1, 0, 0, 1, 0);
    check_and_tick(acc);

    foreach (tbl[i]) begin
      if (tbl[i].drain) begin
        drain();
      end else begin
        drive(tbl[i].rst, tbl[i].valid, tbl[i].len, 1, tbl[i].rx);
        chk($sformatf("tbl%0d_ready", i), s_req_ready, tbl[i].e_rdy);
        chk($sformatf("tbl%0d_credits", i), credits, tbl[i].e_cred);
        chk($sformatf("tbl%0d_outstanding", i), outstanding, tbl[i].e_out);
        chk($sformatf("tbl%0d_cmpl", i), cmpl, tbl[i].e_cmpl);
        chk($sformatf("tbl%0d_ovf", i), err_oversize, tbl[i].e_ovf);
        chk($sformatf("tbl%0d_udf", i), err_underflow, tbl[i].e_udf);
        check_and_tick(acc);
      end
    end

    // Eight one-beat requests fill the length FIFO; the ninth waits on a completion
    for (int i = 0; i < NO; i++) begin
      drive(0, 1, 64, 1, 0);
      chk("full_issue_ready", s_req_ready, 1);
      check_and_tick(acc);
    end
    drive(0, 1, 64, 1, 0);
    chk("full_blocked_ready", s_req_ready, 0);
    chk("full_blocked_credits", credits, 56);
    chk("full_blocked_outstanding", outstanding, 8);
    check_and_tick(acc);
    drive(0, 1, 64, 1, 1);
    chk("full_rx_ready", s_req_ready, 0);
    check_and_tick(acc);
    drive(0, 1, 64, 1, 0);
    chk("full_after_cmpl", cmpl, 1);
    chk("full_after_outstanding", outstanding, 7);
    chk("full_after_credits", credits, 57);
    chk("full_after_ready", s_req_ready, 1);
    check_and_tick(acc);
    drain();

    // Reset in the middle of traffic with 20 credits and three requests in flight
    drive(0, 1, 21 * 64, 1, 0); chk("rst_seq_a", s_req_ready, 1); check_and_tick(acc);
    drive(0, 1, 20 * 64, 1, 0); chk("rst_seq_b", s_req_ready, 1); check_and_tick(acc);
    drive(0, 1,  4 * 64, 1, 0); chk("rst_seq_c", s_req_ready, 1); check_and_tick(acc);
    drive(0, 1, 8192, 1, 1); check_and_tick(acc);
    drive(1, 1, 64, 1, 0);
    chk("rst_pre_credits", credits, 20);
    chk("rst_pre_outstanding", outstanding, 3);
    chk("rst_pre_ovf", err_oversize, 1);
    chk("rst_during_ready", s_req_ready, 1);
    check_and_tick(acc);
    drive(0, 0, 0, 1, 0);
    chk("rst_post_credits", credits, 64);
    chk("rst_post_outstanding", outstanding, 0);
    chk("rst_post_ovf", err_oversize, 0);
    chk("rst_post_udf", err_underflow, 0);
    chk("rst_post_cmpl", cmpl, 0);
    check_and_tick(acc);

    // Randomized traffic; requests are held until accepted or occasionally withdrawn
    hold_valid = 0;
    hold_len   = 0;
    for (int c = 0; c < 4000; c++) begin
      if (!hold_valid && ($urandom % 3 == 0)) begin
        r = int'($urandom % 16);
        if (r == 0)      hold_len = 0;
        else if (r == 1) hold_len = 4097 + int'($urandom % 20000);
        else if (r < 9)  hold_len = 1 + int'($urandom % 256);
        else             hold_len = 1 + int'($urandom % 4096);
        hold_valid = 1;
      end else if (hold_valid && ($urandom % 16 == 0)) begin
        hold_valid = 0;
      end
      drive(($urandom % 600) == 0, hold_valid, hold_valid ? hold_len : 0,
            ($urandom % 4) != 0, ($urandom % 2) == 0);
      check_and_tick(acc);
      if (acc) hold_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
